// File: rtl/ef_gpio8_irq_if.sv
// ef_gpio8_irq_if: condition flags, configuration and status of the
// 8-pin GPIO interrupt stage. The master side drives flags and
// configuration; the slave side (the interrupt stage) returns status.
interface ef_gpio8_irq_if;
  logic [7:0]  pin_hi;
  logic [7:0]  pin_lo;
  logic [7:0]  pin_pe;
  logic [7:0]  pin_ne;
  logic [15:0] mode;
  logic [7:0]  im;
  logic [7:0]  icr;
  logic [7:0]  ris;
  logic [7:0]  mis;
  logic        irq;

  modport master (
    output pin_hi, pin_lo, pin_pe, pin_ne, mode, im, icr,
    input  ris, mis, irq
  );

  modport slave (
    input  pin_hi, pin_lo, pin_pe, pin_ne, mode, im, icr,
    output ris, mis, irq
  );
endinterface

// File: rtl/ef_gpio8_irq.sv
// ef_gpio8_irq: per-pin interrupt condition select, sticky raw status with
// write-1-to-clear, enable mask and a registered interrupt line.
// Optional level debounce filter: define EF_GPIO8_IRQ_DEBOUNCE_EN.
module ef_gpio8_irq #(
  parameter int DEB_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst,
  ef_gpio8_irq_if.slave  bus
);

  // DEB_CYCLES must fit the 8-bit counter range even when the filter is absent.
  if (DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_deb_range
    $error("DEB_CYCLES out of range 1..255");
  end

  logic [7:0] cond;
  logic [7:0] cond_q;
  logic [7:0] ris_q, ris_d;
  logic       irq_q, irq_d;

  // Select one condition flag per pin from its two mode bits.
  always_comb begin
    cond = '0;
    for (int n = 0; n < 8; n++) begin
      case (bus.mode[2*n +: 2])
        2'b00:   cond[n] = bus.pin_hi[n];
        2'b01:   cond[n] = bus.pin_lo[n];
        2'b10:   cond[n] = bus.pin_pe[n];
        default: cond[n] = bus.pin_ne[n];
      endcase
    end
  end

`ifdef EF_GPIO8_IRQ_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES);

  logic [CW-1:0] cnt_q [8];
  logic [CW-1:0] cnt_d [8];
  logic [15:0]   mode_q;

  // Level modes count consecutive true cycles; the count includes the
  // current cycle so a level held DEB_CYCLES cycles latches on its last edge.
  // Edge modes bypass the filter and keep their counter at zero.
  always_comb begin
    cond_q = '0;
    for (int n = 0; n < 8; n++) begin
      cnt_d[n]  = '0;
      cond_q[n] = cond[n];
      if (!bus.mode[2*n+1]) begin
        if (cond[n] && (bus.mode[2*n +: 2] == mode_q[2*n +: 2])) begin
          cnt_d[n] = (cnt_q[n] == DEB_MAX) ? DEB_MAX : cnt_q[n] + 1'b1;
        end
        cond_q[n] = (cnt_d[n] == DEB_MAX);
      end
    end
  end

  // Debounce counters and the previous mode used to detect reconfiguration.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= '0;
      for (int n = 0; n < 8; n++) cnt_q[n] <= '0;
    end else begin
      mode_q <= bus.mode;
      for (int n = 0; n < 8; n++) cnt_q[n] <= cnt_d[n];
    end
  end
`else
  // Without the filter the selected condition feeds status directly.
  always_comb begin
    cond_q = cond;
  end
`endif

  // Sticky status: a new condition wins over a clear in the same cycle.
  always_comb begin
    ris_d = (ris_q & ~bus.icr) | cond_q;
    irq_d = |(ris_q & bus.im);
  end

  // Status and interrupt registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ris_q <= '0;
      irq_q <= 1'b0;
    end else begin
      ris_q <= ris_d;
      irq_q <= irq_d;
    end
  end

  assign bus.ris = ris_q;
  assign bus.mis = ris_q & bus.im;
  assign bus.irq = irq_q;

endmodule

// File: tb/tb_ef_gpio8_irq.sv
// tb_ef_gpio8_irq: directed tests for ef_gpio8_irq; the debounce test is
// included when EF_GPIO8_IRQ_DEBOUNCE_EN is defined.
module tb_ef_gpio8_irq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  ef_gpio8_irq_if ifc ();

  ef_gpio8_irq #(.DEB_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifc.pin_hi = '0; ifc.pin_lo = '0; ifc.pin_pe = '0; ifc.pin_ne = '0;
    ifc.icr = '0;
  endtask

  task automatic clear_all();
    idle_inputs();
    ifc.icr = 8'hFF;
    tick();
    ifc.icr = '0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ifc.pin_hi = 8'($urandom); ifc.pin_lo = 8'($urandom);
      ifc.pin_pe = 8'($urandom); ifc.pin_ne = 8'($urandom);
      ifc.mode = 16'($urandom); ifc.im = 8'($urandom); ifc.icr = 8'($urandom);
      tick();
      n_cmp++; if (ifc.ris !== 8'h00) begin n_err++; $display("FAIL reset_ris: got %h expected 00", ifc.ris); end
      n_cmp++; if (ifc.mis !== 8'h00) begin n_err++; $display("FAIL reset_mis: got %h expected 00", ifc.mis); end
      n_cmp++; if (ifc.irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b expected 0", ifc.irq); end
    end
    idle_inputs();
    ifc.mode = '0; ifc.im = '0;
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (ifc.ris !== 8'h00) begin n_err++; $display("FAIL reset_release_ris: got %h expected 00", ifc.ris); end
  endtask

  task automatic test_edge();
    ifc.mode = 16'h0020; ifc.im = 8'h04;
    tick();
    ifc.pin_pe = 8'h04;
    tick();
    n_cmp++; if (ifc.ris !== 8'h04) begin n_err++; $display("FAIL edge_ris_set: got %h expected 04", ifc.ris); end
    n_cmp++; if (ifc.irq !== 1'b0) begin n_err++; $display("FAIL edge_irq_latency: got %b expected 0", ifc.irq); end
    ifc.pin_pe = 8'h00;
    tick();
    n_cmp++; if (ifc.irq !== 1'b1) begin n_err++; $display("FAIL edge_irq_set: got %b expected 1", ifc.irq); end
    n_cmp++; if (ifc.ris !== 8'h04) begin n_err++; $display("FAIL edge_ris_sticky: got %h expected 04", ifc.ris); end
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (ifc.irq !== 1'b1) begin n_err++; $display("FAIL edge_irq_hold: got %b expected 1", ifc.irq); end
    ifc.icr = 8'h04;
    tick();
    ifc.icr = 8'h00;
    n_cmp++; if (ifc.ris !== 8'h00) begin n_err++; $display("FAIL edge_ris_clear: got %h expected 00", ifc.ris); end
    n_cmp++; if (ifc.irq !== 1'b1) begin n_err++; $display("FAIL edge_irq_fall_latency: got %b expected 1", ifc.irq); end
    tick();
    n_cmp++; if (ifc.irq !== 1'b0) begin n_err++; $display("FAIL edge_irq_clear: got %b expected 0", ifc.irq); end
  endtask

  task automatic test_collision();
    ifc.mode = 16'h0C00; ifc.im = 8'h00;
    tick();
    ifc.pin_ne = 8'h20;
    tick();
    n_cmp++; if (ifc.ris !== 8'h20) begin n_err++; $display("FAIL coll_first_set: got %h expected 20", ifc.ris); end
    ifc.pin_ne = 8'h20; ifc.icr = 8'h20;
    tick();
    n_cmp++; if (ifc.ris !== 8'h20) begin n_err++; $display("FAIL coll_set_wins: got %h expected 20", ifc.ris); end
    ifc.pin_ne = 8'h00;
    tick();
    ifc.icr = 8'h00;
    n_cmp++; if (ifc.ris !== 8'h00) begin n_err++; $display("FAIL coll_clear: got %h expected 00", ifc.ris); end
    n_cmp++; if (ifc.irq !== 1'b0) begin n_err++; $display("FAIL coll_masked_irq: got %b expected 0", ifc.irq); end
  endtask

  task automatic test_mask();
    ifc.mode = 16'h0002; ifc.im = 8'h00;
    tick();
    ifc.pin_pe = 8'h01;
    tick();
    ifc.pin_pe = 8'h00;
    n_cmp++; if (ifc.ris !== 8'h01) begin n_err++; $display("FAIL mask_ris_set: got %h expected 01", ifc.ris); end
    tick();
    n_cmp++; if (ifc.irq !== 1'b0) begin n_err++; $display("FAIL mask_irq_gated: got %b expected 0", ifc.irq); end
    n_cmp++; if (ifc.mis !== 8'h00) begin n_err++; $display("FAIL mask_mis_gated: got %h expected 00", ifc.mis); end
    ifc.im = 8'h01;
    #1;
    n_cmp++; if (ifc.mis !== 8'h01) begin n_err++; $display("FAIL mask_mis_immediate: got %h expected 01", ifc.mis); end
    n_cmp++; if (ifc.irq !== 1'b0) begin n_err++; $display("FAIL mask_irq_not_yet: got %b expected 0", ifc.irq); end
    tick();
    n_cmp++; if (ifc.irq !== 1'b1) begin n_err++; $display("FAIL mask_irq_unmasked: got %b expected 1", ifc.irq); end
    ifc.im = 8'h00;
    tick();
    n_cmp++; if (ifc.irq !== 1'b0) begin n_err++; $display("FAIL mask_irq_remask: got %b expected 0", ifc.irq); end
    n_cmp++; if (ifc.ris !== 8'h01) begin n_err++; $display("FAIL mask_ris_kept: got %h expected 01", ifc.ris); end
    clear_all();
  endtask

  task automatic test_level();
    ifc.mode = 16'h0000; ifc.im = 8'h80;
    ifc.pin_hi = 8'h80;
    for (int i = 0; i < 6; i++) tick();
    n_cmp++; if (ifc.ris !== 8'h80) begin n_err++; $display("FAIL level_hi_set: got %h expected 80", ifc.ris); end
    ifc.icr = 8'h80;
    tick();
    ifc.icr = 8'h00;
    n_cmp++; if (ifc.ris !== 8'h80) begin n_err++; $display("FAIL level_reassert: got %h expected 80", ifc.ris); end
    ifc.pin_hi = 8'h00;
    tick();
    ifc.icr = 8'h80;
    tick();
    ifc.icr = 8'h00;
    n_cmp++; if (ifc.ris !== 8'h00) begin n_err++; $display("FAIL level_cleared: got %h expected 00", ifc.ris); end
    tick();
    n_cmp++; if (ifc.ris !== 8'h00) begin n_err++; $display("FAIL level_stays_clear: got %h expected 00", ifc.ris); end
    // Level-low on pin 1; pin 7 flags stay low so it must not set.
    ifc.mode = 16'h0004; ifc.im = 8'h02;
    ifc.pin_lo = 8'h02; ifc.pin_hi = 8'h01;
    for (int i = 0; i < 6; i++) tick();
    n_cmp++; if (ifc.ris !== 8'h03) begin n_err++; $display("FAIL level_lo_set: got %h expected 03", ifc.ris); end
    n_cmp++; if (ifc.mis !== 8'h02) begin n_err++; $display("FAIL level_lo_mis: got %h expected 02", ifc.mis); end
    clear_all();
  endtask

  task automatic test_multi_and_mode();
    ifc.mode = 16'h0002; ifc.im = 8'h00;
    tick();
    ifc.pin_pe = 8'h01;
    tick();
    ifc.pin_pe = 8'h00;
    ifc.mode = 16'h220B;
    tick();
    n_cmp++; if (ifc.ris !== 8'h01) begin n_err++; $display("FAIL mode_change_keeps_ris: got %h expected 01", ifc.ris); end
    ifc.pin_pe = 8'h52; ifc.pin_ne = 8'h80;
    tick();
    ifc.pin_pe = 8'h00; ifc.pin_ne = 8'h00;
    n_cmp++; if (ifc.ris !== 8'h53) begin n_err++; $display("FAIL multi_ris: got %h expected 53", ifc.ris); end
    ifc.im = 8'h40;
    tick();
    n_cmp++; if (ifc.irq !== 1'b1) begin n_err++; $display("FAIL multi_irq: got %b expected 1", ifc.irq); end
    ifc.icr = 8'h40;
    tick();
    ifc.icr = 8'h00;
    n_cmp++; if (ifc.ris !== 8'h13) begin n_err++; $display("FAIL multi_partial_clear: got %h expected 13", ifc.ris); end
    tick();
    n_cmp++; if (ifc.irq !== 1'b0) begin n_err++; $display("FAIL multi_irq_fall: got %b expected 0", ifc.irq); end
    clear_all();
  endtask

`ifdef EF_GPIO8_IRQ_DEBOUNCE_EN
  task automatic test_debounce();
    ifc.mode = 16'h0000; ifc.im = 8'h08;
    tick();
    ifc.pin_hi = 8'h08;
    for (int i = 0; i < 3; i++) tick();
    ifc.pin_hi = 8'h00;
    n_cmp++; if (ifc.ris !== 8'h00) begin n_err++; $display("FAIL deb_short_pulse: got %h expected 00", ifc.ris); end
    tick();
    n_cmp++; if (ifc.ris !== 8'h00) begin n_err++; $display("FAIL deb_short_after: got %h expected 00", ifc.ris); end
    ifc.pin_hi = 8'h08;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++; if (ifc.ris !== 8'h00) begin n_err++; $display("FAIL deb_third_edge: got %h expected 00", ifc.ris); end
    tick();
    n_cmp++; if (ifc.ris !== 8'h08) begin n_err++; $display("FAIL deb_fourth_edge: got %h expected 08", ifc.ris); end
    clear_all();
    ifc.pin_hi = 8'h08;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++; if (ifc.ris !== 8'h00) begin n_err++; $display("FAIL deb_rst_restart: got %h expected 00", ifc.ris); end
    tick();
    n_cmp++; if (ifc.ris !== 8'h08) begin n_err++; $display("FAIL deb_rst_full_count: got %h expected 08", ifc.ris); end
    clear_all();
  endtask
`endif

  initial begin
    idle_inputs();
    ifc.mode = '0; ifc.im = '0;
    test_reset();
    test_edge();
    test_collision();
    test_mask();
    test_level();
    test_multi_and_mode();
`ifdef EF_GPIO8_IRQ_DEBOUNCE_EN
    test_debounce();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
